// File: rtl/snn_pkg.sv
// Shared width arithmetic and packed-bus helpers for the spiking-synapse blocks.
// Everything here is elaboration-time only; no logic is generated.
package snn_pkg;

    localparam int MAX_DW = 62;

    function automatic int calc_dw(input int width, input int resbit, input int spike_num);
        return width + resbit + spike_num;
    endfunction

    // One extra bit beyond log2(channels) keeps the signed sum overflow-free.
    function automatic int calc_sw(input int dw, input int channels);
        return dw + $clog2(channels) + 1;
    endfunction

    function automatic int calc_cw(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

    function automatic int slice_lo(input int idx, input int slice_width);
        return idx * slice_width;
    endfunction

    function automatic logic [MAX_DW-1:0] sat_const(input int dw);
        return (MAX_DW'(1) << dw) - MAX_DW'(1);
    endfunction

endpackage

// File: rtl/synapse_channel.sv
// One PSP accumulator: spike edge detect, geometric decay on tick, weighted add,
// saturation at full scale.
module synapse_channel
    import snn_pkg::*;
#(
    parameter int p_width       = 6,
    parameter int p_resbit      = 10,
    parameter int p_spike_num   = 2,
    parameter int p_decay_shift = 4,
    localparam int DW           = calc_dw(p_width, p_resbit, p_spike_num)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_event,
    input  logic [p_width-1:0] i_weight,
    output logic [DW-1:0]      o_psp,
    output logic               o_active
);

    localparam logic [DW-1:0] SAT = DW'(sat_const(DW));

    logic [DW-1:0] state_q;
    logic [DW-1:0] state_d;
    logic          event_q;
    logic          spk;
    logic [DW:0]   shifted;
    logic [DW:0]   decay;
    logic [DW:0]   add;
    logic [DW:0]   total;

    assign spk = i_event & ~event_q;

    // Decay is taken before the add so the subtraction can never go negative;
    // the one-LSB floor guarantees a nonzero PSP always drains to zero.
    always_comb begin
        shifted = {1'b0, state_q} >> p_decay_shift;
        decay   = '0;
        if (i_tick) begin
            decay = shifted;
            if (shifted == '0 && state_q != '0) begin
                decay = (DW+1)'(1);
            end
        end
        add = '0;
        if (spk) begin
            add = (DW+1)'(i_weight) << p_resbit;
        end
        total   = {1'b0, state_q} - decay + add;
        state_d = total[DW] ? SAT : total[DW-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= '0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            event_q <= i_event;
        end
    end

    assign o_psp    = state_q;
    assign o_active = |state_q;

endmodule

// File: rtl/synapse_bank.sv
// Bank of independent synapse channels sharing one decay tick, with a signed
// excitatory/inhibitory sum of all PSPs for the downstream neuron.
module synapse_bank
    import snn_pkg::*;
#(
    parameter int p_channels    = 4,
    parameter int p_width       = 6,
    parameter int p_resbit      = 10,
    parameter int p_spike_num   = 2,
    parameter int p_decay_shift = 4,
    parameter int p_tick_div    = 4,
    localparam int DW           = calc_dw(p_width, p_resbit, p_spike_num),
    localparam int SW           = calc_sw(DW, p_channels)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic [p_channels-1:0]         i_event,
    input  logic [p_channels*p_width-1:0] i_weight,
    input  logic [p_channels-1:0]         i_inhib,
    output logic                          o_sync,
    output logic [p_channels*DW-1:0]      o_do,
    output logic [p_channels-1:0]         o_active,
    output logic signed [SW-1:0]          o_sum
);

    localparam int            CW       = calc_cw(p_tick_div);
    localparam logic [CW-1:0] CNT_LAST = CW'(p_tick_div - 1);

    logic [CW-1:0]        cnt_q;
    logic                 tick;
    logic [DW-1:0]        psp [p_channels];
    logic signed [SW-1:0] sum_d;

    assign tick = i_enable && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    for (genvar c = 0; c < p_channels; c++) begin : g_ch
        synapse_channel #(
            .p_width       (p_width),
            .p_resbit      (p_resbit),
            .p_spike_num   (p_spike_num),
            .p_decay_shift (p_decay_shift)
        ) u_channel (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_tick   (tick),
            .i_event  (i_event[c]),
            .i_weight (i_weight[slice_lo(c, p_width) +: p_width]),
            .o_psp    (psp[c]),
            .o_active (o_active[c])
        );

        assign o_do[slice_lo(c, DW) +: DW] = psp[c];
    end

    // PSPs are zero-extended before negation, so inhibitory terms are exact.
    always_comb begin
        sum_d = '0;
        for (int c = 0; c < p_channels; c++) begin
            if (i_inhib[c]) begin
                sum_d = sum_d - signed'(SW'(psp[c]));
            end else begin
                sum_d = sum_d + signed'(SW'(psp[c]));
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sync <= 1'b0;
            o_sum  <= '0;
        end else begin
            o_sync <= tick;
            o_sum  <= sum_d;
        end
    end

endmodule

// File: tb/tb_synapse_bank.sv
// Self-checking bench for synapse_bank at default parameters (DW=18, tick every 4 cycles).
module tb_synapse_bank;

    localparam int CH = 4;
    localparam int W  = 6;
    localparam int DW = 18;
    localparam int SW = 21;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_enable;
    logic [CH-1:0]        i_event;
    logic [CH*W-1:0]      i_weight;
    logic [CH-1:0]        i_inhib;
    logic                 o_sync;
    logic [CH*DW-1:0]     o_do;
    logic [CH-1:0]        o_active;
    logic signed [SW-1:0] o_sum;

    synapse_bank dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_enable),
        .i_event  (i_event),
        .i_weight (i_weight),
        .i_inhib  (i_inhib),
        .o_sync   (o_sync),
        .o_do     (o_do),
        .o_active (o_active),
        .o_sum    (o_sum)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string  name;
        int     kind;
        int     ch;
        longint val;
    } sb_t;

    typedef struct {
        logic [CH-1:0] ev;
        int            w0;
        longint        exp_do0;
        longint        exp_sum;
        logic [CH-1:0] exp_act;
    } vec_t;

    localparam int K_PSP    = 0;
    localparam int K_ACTIVE = 1;
    localparam int K_SUM    = 2;
    localparam int K_SYNC   = 3;

    sb_t  sb_q[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic longint psp_of(input int ch);
        return longint'(o_do[ch*DW +: DW]);
    endfunction

    function automatic longint decay_step(input longint s);
        longint d;
        d = s >> 4;
        if (d == 0 && s != 0) d = 1;
        return s - d;
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input int kind, input int ch, input longint v);
        sb_t it;
        it.name = nm;
        it.kind = kind;
        it.ch   = ch;
        it.val  = v;
        sb_q.push_back(it);
    endtask

    task automatic check_sb();
        sb_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.kind)
                K_PSP:    cmp(it.name, psp_of(it.ch), it.val);
                K_ACTIVE: cmp(it.name, longint'(o_active), it.val);
                K_SUM:    cmp(it.name, longint'(o_sum), it.val);
                default:  cmp(it.name, longint'(o_sync), it.val);
            endcase
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        check_sb();
    endtask

    task automatic set_w(input int ch, input int w);
        i_weight[ch*W +: W] = W'(w);
    endtask

    task automatic do_reset();
        i_rst    = 1'b1;
        i_enable = 1'b0;
        i_event  = '0;
        i_inhib  = '0;
        i_weight = '0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic wait_sync(input int budget, output int cycles);
        cycles = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge i_clk);
            #1;
            cycles++;
            if (o_sync) break;
        end
        if (!o_sync) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_sync: no o_sync within %0d cycles", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     cyc;
        int     zeros;
        longint s;

        // Saturation run: five spikes on ch0, each re-armed by a low cycle.
        vecs[0] = '{4'b0001, 63,  64512,      0, 4'b0001};
        vecs[1] = '{4'b0000, 63,  64512,  64512, 4'b0001};
        vecs[2] = '{4'b0001, 63, 129024,  64512, 4'b0001};
        vecs[3] = '{4'b0000, 63, 129024, 129024, 4'b0001};
        vecs[4] = '{4'b0001, 63, 193536, 129024, 4'b0001};
        vecs[5] = '{4'b0000, 63, 193536, 193536, 4'b0001};
        vecs[6] = '{4'b0001, 63, 258048, 193536, 4'b0001};
        vecs[7] = '{4'b0000, 63, 258048, 258048, 4'b0001};
        vecs[8] = '{4'b0001, 63, 262143, 258048, 4'b0001};
        vecs[9] = '{4'b0000, 63, 262143, 262143, 4'b0001};

        // Reset values while reset is held.
        i_rst    = 1'b1;
        i_enable = 1'b0;
        i_event  = '0;
        i_inhib  = '0;
        i_weight = '0;
        @(posedge i_clk);
        #1;
        for (int c = 0; c < CH; c++) push("reset_psp", K_PSP, c, 0);
        push("reset_active", K_ACTIVE, 0, 0);
        push("reset_sum", K_SUM, 0, 0);
        push("reset_sync", K_SYNC, 0, 0);
        check_sb();
        i_rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            i_event = vecs[v].ev;
            set_w(0, vecs[v].w0);
            push($sformatf("sat_do0[%0d]", v), K_PSP, 0, vecs[v].exp_do0);
            push($sformatf("sat_sum[%0d]", v), K_SUM, 0, vecs[v].exp_sum);
            push($sformatf("sat_active[%0d]", v), K_ACTIVE, 0, longint'(vecs[v].exp_act));
            step();
        end

        // Geometric decay from 64512 and tick latency from a reset counter.
        do_reset();
        i_event = 4'b0001;
        set_w(0, 63);
        push("decay_load", K_PSP, 0, 64512);
        step();
        i_event  = '0;
        i_enable = 1'b1;
        push("decay_tick1", K_PSP, 0, 60480);
        push("decay_sync1", K_SYNC, 0, 1);
        wait_sync(20, cyc);
        check_sb();
        cmp("first_tick_latency", cyc, 4);
        push("decay_tick2", K_PSP, 0, 56700);
        push("decay_sync2", K_SYNC, 0, 1);
        wait_sync(20, cyc);
        check_sb();
        cmp("tick_period", cyc, 4);

        // Event arriving on the tick edge: decay then add.
        do_reset();
        i_event = 4'b0001;
        set_w(0, 63);
        push("te_load", K_PSP, 0, 64512);
        step();
        i_event  = '0;
        i_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push("te_hold_psp", K_PSP, 0, 64512);
            push("te_hold_sync", K_SYNC, 0, 0);
            step();
        end
        i_event = 4'b0001;
        set_w(0, 1);
        push("te_combined", K_PSP, 0, 61504);
        push("te_sync", K_SYNC, 0, 1);
        step();

        // Decay tail down to zero (passes ...5,4,3,2,1,0) and stays there.
        i_event = '0;
        s       = 61504;
        zeros   = 0;
        for (int t = 0; t < 400 && zeros < 3; t++) begin
            s = decay_step(s);
            push("tail_psp", K_PSP, 0, s);
            push("tail_active", K_ACTIVE, 0, (s != 0) ? 1 : 0);
            wait_sync(20, cyc);
            check_sb();
            if (s == 0) zeros++;
        end
        cmp("tail_reached_zero", s, 0);

        // Signed sum with an inhibitory channel, then flipped to excitatory.
        do_reset();
        i_event = 4'b0011;
        set_w(0, 63);
        set_w(1, 10);
        i_inhib = 4'b0010;
        push("inh_psp0", K_PSP, 0, 64512);
        push("inh_psp1", K_PSP, 1, 10240);
        push("inh_active", K_ACTIVE, 0, 3);
        step();
        i_event = '0;
        push("inh_sum", K_SUM, 0, 54272);
        step();
        i_inhib = '0;
        push("exc_sum", K_SUM, 0, 74752);
        step();

        // Level held five cycles adds once; re-arming after a low cycle adds again.
        do_reset();
        set_w(2, 5);
        i_event = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            push("held_psp2", K_PSP, 2, 5120);
            step();
        end
        i_event = '0;
        push("held_low_psp2", K_PSP, 2, 5120);
        step();
        i_event = 4'b0100;
        push("rearm_psp2", K_PSP, 2, 10240);
        push("rearm_active", K_ACTIVE, 0, 4);
        step();

        // Asynchronous reset between edges while a tick is showing.
        do_reset();
        i_event = 4'b0001;
        set_w(0, 63);
        step();
        i_event  = '0;
        i_enable = 1'b1;
        wait_sync(20, cyc);
        #2;
        i_rst = 1'b1;
        #1;
        push("arst_psp0", K_PSP, 0, 0);
        push("arst_sum", K_SUM, 0, 0);
        push("arst_sync", K_SYNC, 0, 0);
        push("arst_active", K_ACTIVE, 0, 0);
        check_sb();
        #2;
        i_rst = 1'b0;
        push("arst_after_psp0", K_PSP, 0, 0);
        push("arst_after_sync", K_SYNC, 0, 1);
        wait_sync(20, cyc);
        check_sb();
        cmp("arst_counter_restart", cyc, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
